// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: sequences load/store/clear requests onto a registered-output RAM
module mem_stage_ctrl #(
  parameter int n  = 2,
  parameter int m  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [n-1:0]  req_addr,
  input  logic [m-1:0]  req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [1:0]    rsp_op,
  output logic [m-1:0]  rsp_rdata,
  output logic          rsp_err,
  output logic [CW-1:0] access_cnt,
  output logic          mem_ce,
  output logic          mem_rw,
  output logic          mem_clr_n,
  output logic [n-1:0]  mem_mar,
  output logic [m-1:0]  mem_din,
  input  logic [m-1:0]  mem_dout
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2, RESP = 2'd3;
  localparam logic [1:0] OP_LOAD = 2'b00, OP_STORE = 2'b01, OP_CLEAR = 2'b10;
  logic [1:0] state;
  // Moore controller: every output is a register; rsp_op doubles as the latched opcode
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_op     <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      access_cnt <= '0;
      mem_ce     <= 1'b0;
      mem_rw     <= 1'b1;
      mem_clr_n  <= 1'b1;
      mem_mar    <= '0;
      mem_din    <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          req_ready <= 1'b0;
          rsp_op    <= req_op;
          rsp_rdata <= '0;
          rsp_err   <= &req_op;
          if (&req_op) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            state     <= ISSUE;
            mem_ce    <= 1'b1;
            mem_mar   <= req_addr;
            mem_rw    <= req_op != OP_STORE;
            mem_clr_n <= req_op != OP_CLEAR;
            mem_din   <= req_op == OP_STORE ? req_wdata : '0;
          end
        end
        ISSUE: if (rsp_op == OP_LOAD) state <= CAPTURE;
        else begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          mem_ce    <= 1'b0;
          mem_rw    <= 1'b1;
          mem_clr_n <= 1'b1;
          mem_mar   <= '0;
          mem_din   <= '0;
        end
        CAPTURE: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= mem_dout;
          mem_ce    <= 1'b0;
          mem_rw    <= 1'b1;
          mem_mar   <= '0;
        end
        default: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          if (!rsp_err && !(&access_cnt)) access_cnt <= access_cnt + 1'b1;
        end
      endcase
    end
endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller placed directly upstream of the pipeline's data RAM. It accepts load, store and clear requests from the execute stage over a valid/ready handshake. It sequences the RAM's `ce`/`rw`/`clr`/`mar`/`dataIn` pins and captures the RAM's registered `dataOut`. It returns one response per request to write-back, and keeps a saturating count of successful accesses.

## Interface
- `n`, default 2: address width; the RAM holds 2**n words.
- `m`, default 8: data width.
- `CW`, default 8: width of `access_cnt`.
- `clk`  input  1: single clock. All state changes on the rising edge.
- `clr`  input  1: reset, asynchronous, active-high.
- `req_valid`  input  1: request present.
- `req_ready`  output  1: controller can accept a request. High only in IDLE.
- `req_op`  input  2: request operation. 00 LOAD, 01 STORE, 10 CLEAR, 11 illegal.
- `req_addr`  input  n: word address.
- `req_wdata`  input  m: store data.
- `rsp_valid`  output  1: response present.
- `rsp_ready`  input  1: write-back accepts the response.
- `rsp_op`  output  2: operation code of the request being answered.
- `rsp_rdata`  output  m: load data. 0 for any non-LOAD response.
- `rsp_err`  output  1: request was illegal; no RAM access was made.
- `access_cnt`  output  CW: count of completed responses with `rsp_err`=0. Saturates at all-ones.
- `mem_ce`, `mem_rw`, `mem_clr_n`  output  1 each: drive the RAM's `ce`, `rw` (1 = read) and `clr` (active-low) pins.
- `mem_mar`  output  n: drives the RAM's address input.
- `mem_din`  output  m: drives the RAM's data input.
- `mem_dout`  input  m: the RAM's registered data output. Tri-stated while `mem_ce`=0.

## Operation
- All outputs are registered (Moore). The state machine has four states: IDLE, ISSUE, CAPTURE, RESP.
- Idle values of the RAM-side outputs: `mem_ce`=0, `mem_rw`=1, `mem_clr_n`=1, `mem_mar`=0, `mem_din`=0.
- **IDLE**
  - `req_ready`=1.
  - When `req_valid`=1, latch op, addr and wdata.
  - If op is 11: go to RESP with `rsp_err`=1, `rsp_rdata`=0.
  - Otherwise: go to ISSUE.
- **ISSUE** (exactly one cycle)
  - `mem_ce`=1 and `mem_mar`=latched addr.
  - LOAD: `mem_rw`=1, `mem_clr_n`=1; next state CAPTURE.
  - STORE: `mem_rw`=0, `mem_din`=latched wdata, `mem_clr_n`=1; next state RESP.
  - CLEAR: `mem_rw`=1 (read, so no write can collide with the clear), `mem_clr_n`=0; next state RESP.
- **CAPTURE** (LOAD only, one cycle)
  - Hold `mem_ce`=1, `mem_rw`=1 and the same `mem_mar`, so `mem_dout` stays stable.
  - Register `mem_dout` into `rsp_rdata` at the end of the cycle.
  - Next state RESP.
- **RESP**
  - `rsp_valid`=1, `req_ready`=0, RAM-side outputs at idle values.
  - `rsp_op`, `rsp_rdata` and `rsp_err` are held stable until `rsp_ready`=1.
  - On the handshake, go to IDLE. If `rsp_err`=0, increment `access_cnt` unless it is all-ones.
- No request is accepted in the cycle a response completes. At most one request is in flight.
- Reset clears the controller's state only. It never clears RAM contents; only a CLEAR request does.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_op`=0, `rsp_rdata`=0, `rsp_err`=0, `access_cnt`=0, RAM-side outputs at idle values.
- Latency is counted from the accepting edge k to the edge after which `rsp_valid` is high:
  - LOAD: edge k+2. The RAM samples at k+1; the controller captures at k+2.
  - STORE and CLEAR: edge k+1. The RAM writes or clears at k+1.
  - Illegal op: edge k.
- Minimum spacing between back-to-back accepts:
  - LOAD: 4 cycles.
  - STORE and CLEAR: 3 cycles.
  - Illegal op: 2 cycles.
- Applies only when `rsp_ready` is held high.
- If `rsp_ready` is low, RESP holds indefinitely and the outputs must not change.
- Reset asserted mid-operation:
  - All outputs go to reset values immediately (asynchronously) and the in-flight request is dropped with no response.
  - If reset rises during ISSUE before edge k+1, the RAM sees `mem_ce`=0 at that edge and performs no write or clear.
- `req_*` inputs are ignored outside IDLE.
- `access_cnt` at all-ones stays at all-ones.

## Test plan
- Reset, then STORE addr 2 data 0xA5, then LOAD addr 2 with `rsp_ready`=1 → STORE response at k+1 with `rsp_rdata`=0. LOAD response at k+2 with `rsp_rdata`=0xA5, `rsp_op`=00. `access_cnt`=2.
- LOAD addr 3 from RAM power-up contents → `rsp_rdata`=0x03. During ISSUE and CAPTURE: `mem_ce`=1, `mem_rw`=1, `mem_mar`=3.
- CLEAR, then LOAD addr 1 → `mem_clr_n` low for exactly one cycle, then `rsp_rdata`=0x00.
- `req_op`=11 → `rsp_err`=1 at edge k. `mem_ce` never rises. `access_cnt` unchanged.
- LOAD with `rsp_ready` held low for 5 cycles → `rsp_valid` and `rsp_rdata` stay constant and `req_ready`=0 throughout. Completes on the first cycle with `rsp_ready`=1.
- STORE addr 0 data 0x5A with `clr` pulsed high during ISSUE, then LOAD addr 0 → no response for the STORE. Outputs return to reset values at once. LOAD returns 0x00 (the power-up value), not 0x5A.
